mem_arbiter: RTL

Two-master, one-slave arbiter that shares the single burst memory port between the instruction cache and the data cache. Each master presents the same memory-side interface that `generic_cache` drives: address, 2-bit burst length, rd/wr strobes, write data, plus read-valid and waitrequest. The arbiter grants one master at a time, round-robin, and holds the grant for a whole burst. It sits between the two cache instances and the `memory` model (or the real memory controller).

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM states, master index and burst helper.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdCmd,
    StRdData,
    StWr
  } arb_state_t;

  typedef logic master_sel_t;

  localparam int unsigned NumMasters = 2;

  function automatic int unsigned burst_beats(input int unsigned burst_len);
    return burst_len + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between two cache masters.
// The grant is held for a whole read or write burst.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BURSTLEN_WIDTH = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     m0_addr,
  input  logic [BURSTLEN_WIDTH-1:0] m0_burst_len,
  input  logic                      m0_rd,
  input  logic                      m0_wr,
  input  logic [DATA_WIDTH-1:0]     m0_wr_data,
  output logic [DATA_WIDTH-1:0]     m0_rd_data,
  output logic                      m0_rd_valid,
  output logic                      m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0]     m1_addr,
  input  logic [BURSTLEN_WIDTH-1:0] m1_burst_len,
  input  logic                      m1_rd,
  input  logic                      m1_wr,
  input  logic [DATA_WIDTH-1:0]     m1_wr_data,
  output logic [DATA_WIDTH-1:0]     m1_rd_data,
  output logic                      m1_rd_valid,
  output logic                      m1_waitrequest,
  output logic [ADDR_WIDTH-1:0]     s_addr,
  output logic [BURSTLEN_WIDTH-1:0] s_burst_len,
  output logic [DATA_WIDTH-1:0]     s_wr_data,
  output logic                      s_rd,
  output logic                      s_wr,
  input  logic [DATA_WIDTH-1:0]     s_rd_data,
  input  logic                      s_rd_valid,
  input  logic                      s_waitrequest
);

  localparam int unsigned CntWidth = BURSTLEN_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]     m_addr  [NumMasters];
  logic [BURSTLEN_WIDTH-1:0] m_len   [NumMasters];
  logic [DATA_WIDTH-1:0]     m_wdata [NumMasters];
  logic [NumMasters-1:0]     m_rd, m_wr, m_req, m_wait, m_rvalid;

  arb_state_t          state_q;
  master_sel_t         grant_q, last_q, grant_d;
  logic [CntWidth-1:0] cnt_q;
  logic                first_q;
  logic                s_rd_acc, s_wr_acc;

  assign m_addr[0]  = m0_addr;
  assign m_addr[1]  = m1_addr;
  assign m_len[0]   = m0_burst_len;
  assign m_len[1]   = m1_burst_len;
  assign m_wdata[0] = m0_wr_data;
  assign m_wdata[1] = m1_wr_data;
  assign m_rd       = {m1_rd, m0_rd};
  assign m_wr       = {m1_wr, m0_wr};
  assign m_req      = m_rd | m_wr;

  // On a tie the master that was not served last wins.
  always_comb begin
    if (m_req[0] && m_req[1]) begin
      grant_d = ~last_q;
    end else begin
      grant_d = m_req[1];
    end
  end

  always_comb begin
    s_addr      = m_addr[grant_q];
    s_burst_len = m_len[grant_q];
    s_wr_data   = m_wdata[grant_q];
    s_rd        = 1'b0;
    s_wr        = 1'b0;
    m_wait      = '1;
    m_rvalid    = '0;
    case (state_q)
      StRdCmd: begin
        s_rd             = m_rd[grant_q];
        m_wait[grant_q]  = s_waitrequest;
      end
      StRdData: m_rvalid[grant_q] = s_rd_valid;
      StWr: begin
        s_wr             = m_wr[grant_q];
        m_wait[grant_q]  = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign s_rd_acc       = s_rd & ~s_waitrequest;
  assign s_wr_acc       = s_wr & ~s_waitrequest;
  assign m0_waitrequest = m_wait[0];
  assign m1_waitrequest = m_wait[1];
  assign m0_rd_valid    = m_rvalid[0];
  assign m1_rd_valid    = m_rvalid[1];
  assign m0_rd_data     = s_rd_data;
  assign m1_rd_data     = s_rd_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (|m_req) begin
            grant_q <= grant_d;
            last_q  <= grant_d;
            first_q <= 1'b1;
            state_q <= m_rd[grant_d] ? StRdCmd : StWr;
          end
        end
        StRdCmd: begin
          if (s_rd_acc) begin
            cnt_q   <= CntWidth'(burst_beats(32'(s_burst_len)));
            state_q <= StRdData;
          end
        end
        StRdData: begin
          if (s_rd_valid) begin
            cnt_q <= cnt_q - CntWidth'(1);
            if (cnt_q == CntWidth'(1)) state_q <= StIdle;
          end
        end
        StWr: begin
          // Counter holds the beats still owed after the current one.
          if (s_wr_acc) begin
            first_q <= 1'b0;
            if (first_q) begin
              cnt_q <= CntWidth'(s_burst_len);
              if (s_burst_len == '0) state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - CntWidth'(1);
              if (cnt_q == CntWidth'(1)) state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
